// File: rtl/ipm_unmask_if.sv
// Handshake and data bundle between the Ibex EX stage and the IPM unmask decoder.
// Signal names follow the existing IPM unit's enable/select port naming.
interface ipm_unmask_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] a_i;
  logic             unmask_en_i;
  logic             unmask_sel_i;
  logic [WIDTH-1:0] result_o;
  logic             valid_o;

  modport master (
    output a_i, unmask_en_i, unmask_sel_i,
    input  result_o, valid_o
  );

  modport slave (
    input  a_i, unmask_en_i, unmask_sel_i,
    output result_o, valid_o
  );
endinterface

// File: rtl/ipm_unmask.sv
// IPM unmask decoder: x = a[0] ^ L'[1]*a[1] ^ ... ^ L'[N-1]*a[N-1] over GF(2^8),
// iterating one shared multiplier over the captured shares, one share per enabled cycle.

module ipm_gfmul (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  logic [7:0] sh;

  always_comb begin
    p  = '0;
    sh = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ sh;
      // xtime: multiply by x and reduce modulo x^8+x^4+x^3+x+1
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
    end
  end
endmodule

module ipm_unmask #(
  parameter int n = 4,
  parameter int k = 1
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  ipm_unmask_if.slave  bus
);
  localparam int N     = n - k + 1;
  localparam int WIDTH = N * 8;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;

  localparam logic [7:0] L_TABLE [4] = '{8'h01, 8'h1B, 8'hFA, 8'hBC};

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      shares_q [N];
  logic [7:0]      shares_d [N];
  logic [7:0]      acc_q, acc_d;
  logic [7:0]      res_q, res_d;
  logic [7:0]      mul_a, mul_b, product;
  logic            last;

  ipm_gfmul u_gfmul (
    .a (mul_a),
    .b (mul_b),
    .p (product)
  );

  assign last = (idx_q == IW'(N - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch;
  // blocking assignments here model pure combinational logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shares_d = shares_q;
    acc_d    = acc_q;
    res_d    = res_q;
    mul_a    = '0;
    mul_b    = '0;

    // Operands stay at zero outside ACC so the multiplier never toggles on idle data.
    if (state_q == ACC) begin
      mul_a = L_TABLE[2'(idx_q)];
      mul_b = shares_q[idx_q];
    end

    if (bus.unmask_en_i) begin
      unique case (state_q)
        IDLE: begin
          if (bus.unmask_sel_i) begin
            for (int i = 0; i < N; i++) begin
              shares_d[i] = bus.a_i[WIDTH-1-8*i -: 8];
            end
            acc_d   = bus.a_i[WIDTH-1 -: 8];
            idx_d   = IW'(1);
            state_d = ACC;
          end
        end
        ACC: begin
          if (!bus.unmask_sel_i) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            acc_d = acc_q ^ product;
            if (last) begin
              res_d   = acc_q ^ product;
              state_d = DONE;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          idx_d   = '0;
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the small share array is reset too, so no stale operand survives a reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      for (int i = 0; i < N; i++) shares_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      shares_q <= shares_d;
    end
  end

  assign bus.result_o = {{(WIDTH-8){1'b0}}, res_q};
  assign bus.valid_o  = (state_q == DONE);

endmodule

// File: doc/ipm_unmask.md
Name: ipm_unmask

Overview:
- Decoder counterpart of the IPM coprocessor's MASK operation. Recombines N packed IPM shares into the plain byte: x = a[0] ^ L'[1]*a[1] ^ ... ^ L'[N-1]*a[N-1], with all products in GF(2^8).
- Sits beside the IPM unit in the Ibex EX stage and uses the same enable/select handshake.
- Uses one shared gfmul instance (AES polynomial 0x11B) iterated over the shares, one share per enabled cycle.

Parameters:
- n, 4, total masking order parameter (same meaning as in the IPM unit).
- k, 1, number of secret bytes per word; fixed at 1 for this block.
- N (local), n-k+1, number of shares; legal range 2..4 (size of the L' table).
- WIDTH (local), N*8, packed operand width.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- a_i  in  WIDTH  packed shares; share i = a_i[WIDTH-1-8i -: 8], so share 0 is the MSB byte.
- unmask_en_i  in  1  dynamic enable; when low, all state, counters and result registers hold.
- unmask_sel_i  in  1  static decoder select; request active while high.
- result_o  out  WIDTH  unmasked byte in [7:0]; bits [WIDTH-1:8] always 0.
- valid_o  out  1  result_o is fresh this cycle.

Behaviour:
- Constants L'[0..3] = 1, 27, 250, 188 (0x01, 0x1B, 0xFA, 0xBC), identical to the IPM unit's table.
- Registers:
  - state_q: IDLE / ACC / DONE.
  - idx_q: $clog2(N) bits.
  - shares_q[0:N-1]: operands captured at start.
  - acc_q: 8-bit accumulator.
  - res_q: 8-bit result.
- Reset values: state IDLE, idx 0, shares 0, acc 0, res 0. Therefore result_o = 0 and valid_o = 0.
- All sequential updates occur only on edges where unmask_en_i = 1.
- IDLE:
  - If unmask_sel_i = 1: capture all shares from a_i, set acc <= share 0, idx <= 1, go to ACC.
  - Otherwise stay in IDLE.
- ACC:
  - gfmul inputs are L'[idx_q] and shares_q[idx_q]. acc <= acc ^ product.
  - If idx_q == N-1: res <= acc ^ product and go to DONE. Otherwise idx <= idx+1.
- DONE: valid_o = 1 combinationally (valid_o = state==DONE). Next enabled edge goes to IDLE, idx <= 0.
- Latency: valid_o is high exactly N enabled edges after the start edge (1 capture edge + N-1 ACC edges).
  - N = 4: 4 enabled edges.
  - valid_o stays high for exactly one enabled cycle. If unmask_en_i is low while in DONE, valid_o stays high until the next enabled edge.
- Abort: unmask_sel_i = 0 on an enabled edge in ACC or DONE forces IDLE. In that case res is not updated and valid_o does not pulse; acc and idx are discarded.
- Inputs: a_i changes after the start edge have no effect, because operands are captured.
- Back-to-back: unmask_sel_i held high starts a new operation in the IDLE cycle following DONE. One idle cycle separates operations.
- result_o holds res_q (zero-extended) until the next successful completion. It is stable between completions.
- Asynchronous reset mid-operation: returns immediately to the reset values. No partial result is ever visible.
- GF arithmetic: XOR for addition; gfmul for multiplication. No carries; all widths are 8 bits.
- Multiplier inputs are driven to 0 when state != ACC, so no operand-dependent toggling occurs while idle.

Test Plan:
- Reset, then a_i = 0x53000000 with sel = en = 1 → valid_o high 4 edges after start; result_o = 0x00000053. valid_o low on the following cycle.
- Single-share unit vectors 0x00010000, 0x00000100, 0x00000001 → result_o = 0x1B, 0xFA, 0xBC respectively. Also a_i = 0x00020000 → 0x36.
- a_i = 0x01010101 → result_o = 0x5C. Change a_i to 0 one cycle after start → result is still 0x5C.
- Same as the previous scenario, but drop unmask_en_i for 3 cycles during ACC → state and idx freeze; valid_o arrives 3 cycles late; result is still 0x5C.
- Start with 0x01010101, then drop unmask_sel_i after 2 ACC edges → FSM returns to IDLE; valid_o never pulses; result_o keeps its previous value. Assert reset_ni low during a later ACC → result_o = 0, valid_o = 0 immediately.
- Round trip: mask x = 0xA7 with random r1..r3 via the IPM MASK op, feed the resulting shares in → result_o = 0xA7. Repeat for 1000 random (x, r) pairs against a GF(2^8) reference model.
